// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: default widths,
// the halt opcode, the fetch FSM state type and the FIFO entry layout.
// Optional feature macro used by fetch_stage: FETCH_STAGE_WRAP_EN.
package fetch_pkg;

  localparam int ADDR_W_DEF  = 4;
  localparam int INSTR_W_DEF = 8;

  // Opcode/register pattern that stops the fetch stream
  localparam logic [7:0] HALT_INSTR = 8'hFF;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  // One buffered fetch result at the default widths
  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;

  // True when the fetched word is the halt opcode
  function automatic logic is_halt_word(input logic [INSTR_W_DEF-1:0] word);
    return (word == HALT_INSTR);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} buffer between fetch and decode.
// Push and pop may happen together, also when full; flush empties it.
// The head reads as zero while the buffer is empty.
module fetch_fifo #(
  parameter int AW = 4,
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [AW-1:0] push_pc,
  input  logic [IW-1:0] push_instr,
  output logic [1:0]    count,
  output logic [AW-1:0] head_pc,
  output logic [IW-1:0] head_instr
);

  logic [AW-1:0] pc_mem_r    [2];
  logic [IW-1:0] instr_mem_r [2];
  logic          rd_ptr_r;
  logic          wr_ptr_r;
  logic [1:0]    count_r;
  logic          pop_s;
  logic          push_s;

  // Qualify requests: never pop empty, push into a full buffer only alongside a pop
  always_comb begin
    pop_s  = 1'b0;
    push_s = 1'b0;
    if (count_r != 2'd0) begin
      pop_s = pop;
    end else begin
      pop_s = 1'b0;
    end
    if ((count_r != 2'd2) || pop_s) begin
      push_s = push;
    end else begin
      push_s = 1'b0;
    end
  end

  // Storage, pointers and occupancy; flush wins over push/pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        pc_mem_r[i]    <= '0;
        instr_mem_r[i] <= '0;
      end
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (flush) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        pc_mem_r[wr_ptr_r]    <= push_pc;
        instr_mem_r[wr_ptr_r] <= push_instr;
        wr_ptr_r              <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Head view, forced to zero while empty so stale data never shows
  always_comb begin
    head_pc    = '0;
    head_instr = '0;
    if (count_r != 2'd0) begin
      head_pc    = pc_mem_r[rd_ptr_r];
      head_instr = instr_mem_r[rd_ptr_r];
    end else begin
      head_pc    = '0;
      head_instr = '0;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: program counter, FETCH/DRAIN/HALT control and a
// two-entry output buffer feeding decode. Redirect restarts fetch anywhere.
// Macro FETCH_STAGE_WRAP_EN: when defined the pc wraps from the top address
// to 0 and fetch continues; otherwise the top address is the last fetch.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               out_ready,
  output logic               halted
);

  localparam logic [ADDR_W-1:0]  PC_LAST   = {ADDR_W{1'b1}};
  localparam logic [INSTR_W-1:0] HALT_WORD = INSTR_W'(HALT_INSTR);

  fetch_state_e       state_r;
  fetch_state_e       state_nxt_s;
  logic [ADDR_W-1:0]  pc_r;
  logic [ADDR_W-1:0]  pc_nxt_s;
  logic [1:0]         fifo_count_s;
  logic               transfer_s;
  logic               fetch_s;
  logic               flush_s;
  logic               halt_word_s;
  logic               last_pc_s;

  assign transfer_s  = out_valid && out_ready;
  assign halt_word_s = (imem_data == HALT_WORD);

`ifdef FETCH_STAGE_WRAP_EN
  assign last_pc_s = 1'b0;
`else
  assign last_pc_s = (pc_r == PC_LAST);
`endif

  // State and program counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_FETCH;
      pc_r    <= '0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
    end
  end

  // Next-state, next-pc and buffer control; redirect overrides everything
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    fetch_s     = 1'b0;
    flush_s     = 1'b0;
    if (redirect_valid) begin
      flush_s     = 1'b1;
      pc_nxt_s    = redirect_addr;
      state_nxt_s = ST_FETCH;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if ((fifo_count_s != 2'd2) || transfer_s) begin
            fetch_s  = 1'b1;
            pc_nxt_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (halt_word_s || last_pc_s) begin
              state_nxt_s = ST_DRAIN;
            end else begin
              state_nxt_s = ST_FETCH;
            end
          end else begin
            state_nxt_s = ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if ((fifo_count_s == 2'd0) ||
              ((fifo_count_s == 2'd1) && transfer_s)) begin
            state_nxt_s = ST_HALT;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end
        ST_HALT: begin
          state_nxt_s = ST_HALT;
        end
        default: begin
          flush_s     = 1'b1;
          state_nxt_s = ST_FETCH;
        end
      endcase
    end
  end

  fetch_fifo #(
    .AW(ADDR_W),
    .IW(INSTR_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fetch_s),
    .pop        (transfer_s),
    .flush      (flush_s),
    .push_pc    (pc_r),
    .push_instr (imem_data),
    .count      (fifo_count_s),
    .head_pc    (out_pc),
    .head_instr (out_instr)
  );

  assign imem_addr = pc_r;
  assign out_valid = (fifo_count_s != 2'd0);
  assign halted    = (state_r == ST_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, backpressure, redirect,
// early halt, pc wrap / last fetch and asynchronous reset mid-run.
module tb_fetch_stage;

  logic       clk;
  logic       rst;
  logic [3:0] imem_addr;
  logic [7:0] imem_data;
  logic       redirect_valid;
  logic [3:0] redirect_addr;
  logic       out_valid;
  logic [7:0] out_instr;
  logic [3:0] out_pc;
  logic       out_ready;
  logic       halted;

  logic [7:0] imem [16];
  int n_assert;
  int n_fail;

  assign imem_data = imem[imem_addr];

  fetch_stage #(.ADDR_W(4), .INSTR_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_stream(input logic [7:0] last_word);
    for (int i = 0; i < 15; i++) begin
      imem[i] = {i[3:0], i[3:0]};
    end
    imem[15] = last_word;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_addr", {28'd0, imem_addr}, 32'd0);
    chk("rst_instr", {24'd0, out_instr}, 32'd0);
    chk("rst_pc", {28'd0, out_pc}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] pc, input logic [7:0] instr);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_pc"}, {28'd0, out_pc}, {28'd0, pc});
    chk({tag, "_instr"}, {24'd0, out_instr}, {24'd0, instr});
  endtask

  initial begin
    logic [3:0] p;
    n_assert = 0;
    n_fail = 0;
    rst = 1'b0;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr = 4'd0;

    // ---- Streaming with halt word at 15 ----
    load_stream(8'hFF);
    out_ready = 1'b1;
    apply_reset();
    chk("lat_before", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      p = i[3:0];
      chk_out("stream", p, (i == 15) ? 8'hFF : {p, p});
    end
    tick();
    chk("stream_halted", {31'd0, halted}, 32'd1);
    chk("stream_empty", {31'd0, out_valid}, 32'd0);

    // ---- Backpressure ----
    out_ready = 1'b0;
    apply_reset();
    repeat (5) tick();
    chk_out("bp_hold", 4'd0, 8'h00);
    chk("bp_addr", {28'd0, imem_addr}, 32'd2);
    out_ready = 1'b1;
    for (int i = 1; i < 6; i++) begin
      tick();
      p = i[3:0];
      chk_out("bp_resume", p, {p, p});
    end

    // ---- Redirect ----
    apply_reset();
    repeat (7) tick();
    chk_out("rd_pre", 4'd6, 8'h66);
    redirect_valid = 1'b1;
    redirect_addr = 4'd2;
    tick();
    redirect_valid = 1'b0;
    chk("rd_flush", {31'd0, out_valid}, 32'd0);
    chk("rd_addr", {28'd0, imem_addr}, 32'd2);
    tick();
    chk_out("rd_first", 4'd2, 8'h22);
    tick();
    chk_out("rd_second", 4'd3, 8'h33);

    // ---- Early halt at 4 ----
    load_stream(8'hFF);
    imem[4] = 8'hFF;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      p = i[3:0];
      chk_out("eh", p, (i == 4) ? 8'hFF : {p, p});
    end
    tick();
    chk("eh_halted", {31'd0, halted}, 32'd1);
    tick();
    chk("eh_halted_hold", {31'd0, halted}, 32'd1);
    chk("eh_empty", {31'd0, out_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_addr = 4'd0;
    tick();
    redirect_valid = 1'b0;
    chk("eh_unhalt", {31'd0, halted}, 32'd0);
    tick();
    chk_out("eh_restart", 4'd0, 8'h00);

    // ---- Wrap / last fetch without halt word ----
    load_stream(8'hF0);
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      tick();
      p = i[3:0];
      chk_out("wrap", p, (i == 15) ? 8'hF0 : {p, p});
    end
    tick();
`ifdef FETCH_STAGE_WRAP_EN
    chk_out("wrap_to0", 4'd0, 8'h00);
    chk("wrap_halted", {31'd0, halted}, 32'd0);
`else
    chk("last_halted", {31'd0, halted}, 32'd1);
    chk("last_empty", {31'd0, out_valid}, 32'd0);
`endif

    // ---- Asynchronous reset mid-run ----
    load_stream(8'hFF);
    apply_reset();
    repeat (8) tick();
    chk_out("mr_pre", 4'd7, 8'h77);
    out_ready = 1'b0;
    tick();
    chk("mr_full_addr", {28'd0, imem_addr}, 32'd9);
    chk_out("mr_full_head", 4'd7, 8'h77);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_async_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_async_addr", {28'd0, imem_addr}, 32'd0);
    chk("mr_async_pc", {28'd0, out_pc}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    chk_out("mr_restart0", 4'd0, 8'h00);
    tick();
    chk_out("mr_restart1", 4'd1, 8'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameters: ADDR_W, default 4, instruction-memory address width (16 words); INSTR_W, default 8, instruction width, format [OPCODE 4][REG 4].
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_addr  out  ADDR_W  address to instruction memory.
- imem_data  in  INSTR_W  same-cycle combinational read data for imem_addr.
- redirect_valid  in  1  one-cycle request to restart fetch at a new address.
- redirect_addr  in  ADDR_W  restart address.
- out_valid  out  1  instruction available to the decode/execute stage.
- out_instr  out  INSTR_W  instruction at FIFO head.
- out_pc  out  ADDR_W  address of out_instr.
- out_ready  in  1  consumer accepts the head this cycle.
- halted  out  1  fetch has stopped and FIFO is empty.

Function
REQ-003 SHALL hold a program counter pc; imem_addr SHALL equal pc at all times.
REQ-004 SHALL buffer fetched {pc, instr} pairs in a 2-entry FIFO; out_valid = (count != 0); out_instr/out_pc = head entry.
REQ-005 A transfer SHALL occur on a cycle with out_valid && out_ready; head is popped at that edge.
REQ-006 Fetch SHALL occur on a cycle where state == FETCH, redirect_valid == 0, and (count < 2 or a transfer occurs); fetch pushes {pc, imem_data} and increments pc at that edge.
REQ-007 Full FIFO with out_ready == 0 SHALL stall: pc, imem_addr, FIFO contents held.
REQ-008 States: FETCH, DRAIN, HALT; after reset, state = FETCH.
REQ-009 FETCH -> DRAIN when the fetched word equals 8'hFF (halt opcode); the 8'hFF word is still pushed and delivered.
REQ-010 DRAIN: no fetch; DRAIN -> HALT on the edge at which the FIFO becomes empty.
REQ-011 halted SHALL be 1 only in HALT; HALT is left only by redirect or reset.
REQ-012 Redirect has priority over all else: at that edge the FIFO is cleared, pc <= redirect_addr, state <= FETCH, and no fetch occurs in the redirect cycle.
REQ-013 A transfer coinciding with redirect SHALL count as accepted by the consumer; the FIFO is still cleared.
REQ-014 Latency: the first out_valid SHALL appear one edge after the first rising edge with rst high; with out_ready held at 1, the stage SHALL sustain one instruction per cycle.
REQ-015 Simultaneous push and pop on a 1-entry FIFO SHALL keep count at 1, with the head replaced by the new entry.

Reset
REQ-016 While rst is low: pc = 0, count = 0, state = FETCH, out_valid = 0, out_instr = 0, out_pc = 0, halted = 0, imem_addr = 0.
REQ-017 Asserting rst mid-operation SHALL discard the FIFO and any pending halt or redirect immediately, without waiting for a clock edge.

Configuration
REQ-018 Macro FETCH_STAGE_WRAP_EN:
- Defined: pc wraps from 2^ADDR_W-1 to 0 and fetch continues.
- Undefined: a fetch at pc 2^ADDR_W-1 acts as the last fetch and the state goes FETCH -> DRAIN, as in REQ-009.

Structure
REQ-019 A shared package fetch_pkg SHALL hold ADDR_W/INSTR_W defaults, HALT_INSTR = 8'hFF, the fetch state enum typedef, and the FIFO entry struct typedef {pc, instr}.
REQ-020 The 2-entry buffer SHALL be a sub-module fetch_fifo (push, pop, flush, count, head); the FSM and pc SHALL live in fetch_stage.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Streaming: imem[i] = {i, i} for i = 0..14, imem[15] = 8'hFF; out_ready = 1 -> outputs 0x00, 0x11 ... 0xEE, 0xFF with out_pc 0..15 on consecutive cycles; halted = 1 on the cycle after 0xFF is accepted.
- Backpressure: out_ready = 0 for 5 cycles after reset -> FIFO holds 0x00 (pc 0) and 0x11 (pc 1); imem_addr = 2 held; on release, output resumes with 0x00 and no loss or duplication.
- Redirect: redirect_valid pulse with redirect_addr = 2 while out_pc = 6 -> next out_valid shows 0x22 / pc 2; the pre-redirect entry at pc 7 is never output.
- Early halt: imem[4] = 8'hFF -> outputs pc 0..4, then halted; a redirect to 0 afterwards clears halted and restarts at 0x00.
- Wrap: no 8'hFF in memory -> with FETCH_STAGE_WRAP_EN, pc 15 is followed by pc 0; without it, halted = 1 after pc 15 is accepted.
- Reset mid-run: rst low at pc 9 with a full FIFO -> out_valid = 0 and imem_addr = 0 immediately; after release, output restarts at 0x00.
